// File: rtl/instruction_loader.sv
// Instruction memory load sequencer: assembles little-endian words from the
// debug UART byte stream and strobes them into instruction memory.
module instruction_loader #(
    parameter int WORD_WIDTH_BITS = 32,
    parameter int BYTE_WIDTH      = 8,
    parameter int MEM_SIZE_WORDS  = 10,
    parameter logic [WORD_WIDTH_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int COUNT_WIDTH     = $clog2(MEM_SIZE_WORDS + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [BYTE_WIDTH-1:0]      i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_mem_full,
    output logic                       o_clear,
    output logic                       o_inst_write,
    output logic [WORD_WIDTH_BITS-1:0] o_instruction,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [COUNT_WIDTH-1:0]     o_word_count
);

    localparam int BYTES = WORD_WIDTH_BITS / BYTE_WIDTH;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCW-1:0]         LAST_LANE = BCW'(BYTES - 1);
    localparam logic [TW-1:0]          TMO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]          TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = COUNT_WIDTH'(MEM_SIZE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                     state_q, state_d;
    logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [WORD_WIDTH_BITS-1:0] asm_q, asm_d;
    logic [WORD_WIDTH_BITS-1:0] inst_q, inst_d;
    logic                       wr_q, wr_d;
    logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            asm_q      <= '0;
            inst_q     <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            asm_q      <= asm_d;
            inst_q     <= inst_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        asm_d      = asm_q;
        inst_d     = inst_q;
        wr_d       = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                byte_cnt_d = '0;
                tmo_d      = '0;
                asm_d      = '0;
                inst_d     = '0;
                cnt_d      = '0;
                state_d    = S_RECV;
            end
            S_RECV: begin
                if (i_rx_valid) begin
                    asm_d[int'(byte_cnt_q)*BYTE_WIDTH +: BYTE_WIDTH] = i_rx_data;
                    tmo_d = '0;
                    if (byte_cnt_q == LAST_LANE) begin
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                        // Strobe is registered, so the full flag is sampled
                        // on the edge that enters WRITE.
                        if (!i_mem_full) begin
                            wr_d   = 1'b1;
                            inst_d = asm_d;
                            cnt_d  = cnt_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (byte_cnt_q != '0) begin
                    if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
                    if (tmo_q >= TMO_LAST) state_d = S_ERROR;
                end
            end
            S_WRITE: begin
                if (!wr_q) begin
                    state_d = S_ERROR;
                end else if (inst_q == HALT_WORD) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE, S_ERROR: begin
                if (i_start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_clear       = (state_q == S_CLEAR);
    assign o_inst_write  = wr_q;
    assign o_instruction = inst_q;
    assign o_busy        = (state_q == S_CLEAR) || (state_q == S_RECV) ||
                           (state_q == S_WRITE);
    assign o_done        = (state_q == S_DONE);
    assign o_error       = (state_q == S_ERROR);
    assign o_word_count  = cnt_q;

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Load sequencer for the instruction memory in the instruction-fetch stage.
- Takes a byte stream from the debug UART receiver and assembles 32-bit instructions, little-endian.
- Clears the memory, then drives one-cycle write strobes into it until it sees the HALT word, the word limit or a fault.
- Reports busy/done/error status to the debug unit.

Parameters:
WORD_WIDTH_BITS, 32, instruction width
BYTE_WIDTH, 8, UART byte width
MEM_SIZE_WORDS, 10, instruction memory capacity in words
HALT_WORD, 32'hFFFF_FFFF, end-of-program marker (written to memory, then load completes)
TIMEOUT_CYCLES, 1000000, max idle cycles allowed between bytes of a partially received word
COUNT_WIDTH, $clog2(MEM_SIZE_WORDS+1), width of o_word_count

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_start  in  1  start-load pulse from debug unit
i_rx_data  in  BYTE_WIDTH  received UART byte
i_rx_valid  in  1  i_rx_data valid, one-cycle pulse per byte
i_mem_full  in  1  instruction memory full flag
o_clear  out  1  clear strobe to instruction memory
o_inst_write  out  1  write strobe to instruction memory
o_instruction  out  WORD_WIDTH_BITS  assembled instruction to memory
o_busy  out  1  load in progress (CLEAR/RECV/WRITE)
o_done  out  1  load finished with HALT written
o_error  out  1  load aborted
o_word_count  out  COUNT_WIDTH  words written in current load

Behaviour:
- Reset (i_reset on posedge i_clk):
  - State goes to IDLE; byte counter, word counter, timeout counter and assembly register go to 0.
  - Every output is 0.
  - Reset overrides everything, including mid-load; a partial word is discarded with no write.
- All outputs are registered (Moore, decoded from state/registers).
- FSM states: IDLE, CLEAR, RECV, WRITE, DONE, ERROR.
- IDLE:
  - i_start -> CLEAR.
  - i_rx_valid is ignored.
- CLEAR:
  - Lasts exactly one cycle; o_clear=1.
  - Zeroes byte count, word count, timeout and assembly register.
  - -> RECV.
- RECV:
  - Each i_rx_valid places i_rx_data into byte lane byte_cnt. First byte goes to [7:0], fourth to [31:24].
  - Each byte increments byte_cnt and zeroes the timeout counter.
  - On the 4th byte: byte_cnt wraps to 0 and the state goes to WRITE. The byte sampled at edge N gives WRITE during cycle N..N+1; memory captures at edge N+1.
  - While byte_cnt!=0 with no byte, the timeout counter increments. When it reaches TIMEOUT_CYCLES -> ERROR, no write.
  - While byte_cnt==0 there is no timeout; it waits indefinitely.
- WRITE (one cycle):
  - If i_mem_full=1: o_inst_write stays 0 -> ERROR.
  - Otherwise: o_inst_write=1 and o_instruction=assembled word, both valid in this cycle only; o_word_count increments.
  - Next state:
    - word==HALT_WORD -> DONE.
    - else new count==MEM_SIZE_WORDS -> ERROR (program without HALT).
    - else -> RECV.
  - i_rx_valid during WRITE is dropped. Safe because UART byte spacing is at least 10 bit-times.
- DONE: o_done=1 held. i_start -> CLEAR (reload).
- ERROR: o_error=1 held. i_start -> CLEAR.
- Status and hold rules:
  - o_busy=1 in CLEAR, RECV and WRITE.
  - i_start is ignored while o_busy=1.
  - o_done and o_error are never high together. Both drop on entering CLEAR.
  - o_word_count holds its final value in DONE/ERROR until the next CLEAR.
  - o_instruction holds the last written word outside WRITE; it is 0 after reset/CLEAR.
- Timeout counter saturates; it is sized $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. Reset check: assert i_reset 2 cycles -> all outputs 0; state IDLE; a byte pulse in IDLE causes no write.
2. Nominal load: i_start, then bytes 78 56 34 12 FF FF FF FF ->
   - o_clear high exactly 1 cycle.
   - Two o_inst_write pulses, carrying 32'h12345678 then 32'hFFFFFFFF.
   - o_done=1, o_word_count=2, o_busy=0.
3. Capacity overrun: load 10 non-HALT words (e.g. 32'h0000_0001..0A) -> 10 write pulses, then o_error=1, o_word_count=10.
4. Timeout: TIMEOUT_CYCLES=16; send 2 bytes, then silence -> o_error=1 exactly 16 cycles after 2nd byte; no o_inst_write.
5. Robustness:
   - i_start pulsed during RECV -> ignored; load proceeds normally.
   - i_reset after 3 bytes -> IDLE, all outputs 0, no write.
   - New i_start, then a full program -> loads correctly.
6. Memory full guard: force i_mem_full=1, send 4 bytes -> no o_inst_write; o_error=1; o_word_count unchanged (0). Then i_start -> o_error clears and o_clear pulses.
